uart_word_loader: RTL and testbench
===================================

// Module: uart_word_loader
// PURPOSE
//  UART 8N1 receiver and word assembler for program loading over uart_rxd.
//  Bytes arrive little-endian: the first byte of each group of four lands in [7:0].
//  Each completed word is written to the instruction/data memory write port at
//  consecutive word addresses. done is raised once 2**ADDR_W words are written.
//  This block is the receiving end of UARTTX.
// PARAMETERS
//  SERIAL_WCNT  868  clocks per UART bit (100MHz/115200); legal minimum 2
//  ADDR_W       17   word-address width; image size = 2**ADDR_W words (512KB)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  rxd        in   1       UART serial input, idle high, asynchronous to clk
//  wr_en      out  1       write request; held until accepted
//  wr_ready   in   1       memory accepts a write on a cycle with wr_en&&wr_ready
//  wr_addr    out  ADDR_W  word address of the pending write
//  wr_data    out  32      word data of the pending write
//  done       out  1       sticky; all 2**ADDR_W words written
//  frame_err  out  1       1-cycle pulse when a stop bit is sampled low
//  overrun    out  1       sticky; a word completed while the previous word was still pending
//  checksum   out  32      running sum of accepted words (see CONFIGURATION)
// BEHAVIOUR
//  Reset: wr_en=0, wr_addr=0, wr_data=0, done=0, frame_err=0, overrun=0, checksum=0.
//   RX FSM goes to IDLE; the synchronizer presets to 1. Any partial byte or word is discarded.
//  rxd passes a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
//  RX FSM (bit counter cnt, width $clog2(SERIAL_WCNT)+1):
//   IDLE : rx_s==0 -> START, cnt=0.
//   START: at cnt==SERIAL_WCNT/2-1 sample (mid-bit). If 0 -> DATA, bit=0, cnt=0.
//          If 1, it is a false start -> IDLE, nothing reported.
//   DATA : every SERIAL_WCNT clocks sample one bit, LSB first. After bit 7 -> STOP.
//   STOP : after SERIAL_WCNT clocks sample the stop bit.
//          If 1: byte is valid. If 0: frame_err pulses, byte is dropped,
//          the byte index is not advanced. Next state -> IDLE in both cases.
//  Word assembly: byte index k=0..3; byte k goes to bits [8k+7:8k].
//   When the 4th byte is valid the word is complete and k returns to 0.
//  Write port:
//   - On word complete with wr_en==0: wr_en=1 next cycle, with wr_data=word.
//   - On wr_en&&wr_ready: wr_en=0 next cycle and wr_addr increments (wraps at 2**ADDR_W).
//   - On word complete with wr_en==1 and no handshake that cycle: overrun=1;
//     the new word is dropped and the pending write is kept.
//   - If the handshake and word completion happen in the same cycle: the new word
//     is issued next cycle with wr_en=1 at the incremented address; no overrun.
//  done: set on the handshake of the word at wr_addr==2**ADDR_W-1 (wr_addr wraps to 0).
//   While done==1, received bytes are ignored (FSM keeps running, no writes, no overrun).
//   frame_err still pulses on bad frames.
//  wr_addr/wr_data are stable while wr_en==1. Minimum latency from the 4th stop-bit
//   sample to wr_en=1 is 1 cycle.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - checksum += wr_data (mod 2**32) on each handshake.
//   - checksum holds its value after done.
//  LOADER_CHECKSUM_EN undefined:
//   - checksum is tied to 32'h0 and the adder is not built.
// TESTING (SERIAL_WCNT=4, ADDR_W=2, wr_ready=1 unless stated)
//  1 Send 0x78,0x56,0x34,0x12 -> one wr_en pulse, wr_addr=0, wr_data=32'h12345678.
//  2 Send 16 bytes -> writes at addr 0,1,2,3; done=1 after the 4th handshake.
//    A further byte produces no wr_en.
//  3 Low glitch of 1 clk on rxd in IDLE -> false start.
//    No byte, no frame_err; the next full word is still written at the correct address.
//  4 Byte 0xAA with stop bit forced 0 -> frame_err pulses 1 cycle, byte dropped.
//    The following 4 good bytes form word 0.
//  5 Hold wr_ready=0 across 2 full words -> first word stays on the port, overrun=1.
//    After wr_ready=1, wr_addr=1 and the second word is not written.
//  6 Assert rst during bit 3 of byte 2 -> all outputs reset.
//    The next 4 bytes are written at addr 0. With LOADER_CHECKSUM_EN, after
//    words 1,2,3,4 checksum=32'h0000000A; without the macro, checksum=0.

Source files
------------

// File: rtl/uart_word_loader.sv
// uart_word_loader: UART 8N1 receiver that packs little-endian bytes into words for a memory write port.
// Define LOADER_CHECKSUM_EN to build the running checksum of accepted words; otherwise checksum reads 0.
module uart_word_loader #(
  parameter int SERIAL_WCNT = 868,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              frame_err,
  output logic              overrun,
  output logic [31:0]       checksum
);
  localparam int CW = $clog2(SERIAL_WCNT) + 1;
  localparam logic [CW-1:0] HALF = CW'(SERIAL_WCNT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(SERIAL_WCNT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state, w_state_nx;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_shift;
  logic [1:0]    r_k;
  logic [23:0]   r_word;
  logic          w_rx_s, w_bit_tick, w_stop_tick, w_accept, w_hs, w_last, w_complete;
  assign w_rx_s = r_sync[1];
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt + 1'b1;
    w_bit_nx    = r_bit;
    w_bit_tick  = 1'b0;
    w_stop_tick = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (!w_rx_s) w_state_nx = START;
      end
      START: if (r_cnt == HALF) begin
        w_cnt_nx   = '0;
        w_bit_nx   = '0;
        w_state_nx = w_rx_s ? IDLE : DATA;
      end
      DATA: if (r_cnt == FULL) begin
        w_cnt_nx   = '0;
        w_bit_tick = 1'b1;
        w_bit_nx   = r_bit + 3'd1;
        if (r_bit == 3'd7) w_state_nx = STOP;
      end
      STOP: if (r_cnt == FULL) begin
        w_cnt_nx    = '0;
        w_stop_tick = 1'b1;
        w_state_nx  = IDLE;
      end
    endcase
  end
  // A word finishing on the same edge as the final handshake is dropped: the image is complete.
  assign w_accept   = w_stop_tick && w_rx_s && !done;
  assign w_hs       = wr_en && wr_ready;
  assign w_last     = w_hs && (wr_addr == '1);
  assign w_complete = w_accept && (r_k == 2'd3) && !w_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_k       <= '0;
      r_word    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rxd};
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_bit     <= w_bit_nx;
      frame_err <= w_stop_tick && !w_rx_s;
      if (w_bit_tick) r_shift <= {w_rx_s, r_shift[7:1]};
      if (w_accept) r_k <= r_k + 2'd1;
      if (w_accept && r_k != 2'd3) r_word[{r_k, 3'b000} +: 8] <= r_shift;
      if (w_hs) wr_addr <= wr_addr + 1'b1;
      if (w_last) done <= 1'b1;
      if (w_complete && (!wr_en || w_hs)) begin
        wr_en   <= 1'b1;
        wr_data <= {r_shift, r_word};
      end else if (w_hs) begin
        wr_en <= 1'b0;
      end
      if (w_complete && wr_en && !w_hs) overrun <= 1'b1;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
  always_ff @(posedge clk) begin
    if (rst) r_sum <= '0;
    else if (w_hs) r_sum <= r_sum + wr_data;
  end
  assign checksum = r_sum;
`else
  assign checksum = 32'h0;
`endif
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: table vectors, corner sequences and random frames against a byte-queue model.
module tb_uart_word_loader;
  localparam int SW = 4;
  localparam int AW = 2;
  logic          clk = 1'b0, rst = 1'b1, rxd = 1'b1, wr_ready = 1'b1;
  logic          wr_en, done, frame_err, overrun;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data, checksum;
  uart_word_loader #(.SERIAL_WCNT(SW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .frame_err(frame_err),
    .overrun(overrun), .checksum(checksum)
  );
  always #5 clk = ~clk;
  int            checks = 0, errors = 0;
  logic [AW-1:0] hs_addr[$];
  logic [31:0]   hs_data[$];
  int            fe_cnt = 0, fe_long = 0;
  logic          prev_fe = 1'b0;
  bit            rand_ready = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en && wr_ready) begin
        hs_addr.push_back(wr_addr);
        hs_data.push_back(wr_data);
      end
      if (frame_err) fe_cnt++;
      if (frame_err && prev_fe) fe_long++;
    end
    prev_fe = frame_err;
  end
  typedef struct {
    logic [31:0] seq;
    logic [31:0] data;
  } vec_t;
  vec_t tbl[4];
  function automatic logic [31:0] exp_ck(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic clear_mon();
    hs_addr.delete();
    hs_data.delete();
    fe_cnt = 0;
    fe_long = 0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    clear_mon();
    tick(2);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      tick(SW);
    end
    rxd = 1'b1;
    tick(4);
  endtask
  task automatic send_seq(input logic [31:0] seq);
    for (int i = 0; i < 4; i++) send_byte(seq[31-8*i -: 8]);
  endtask
  task automatic wait_hs(input int n, input string name);
    int c = 0;
    while (hs_addr.size() < n && c < 300) begin
      tick();
      c++;
    end
    check({name, " writes"}, 32'(hs_addr.size()), 32'(n));
  endtask
  task automatic check_write(input int idx, input string name, input logic [AW-1:0] a, input logic [31:0] d);
    if (hs_addr.size() > idx) begin
      check({name, " addr"}, 32'(hs_addr[idx]), 32'(a));
      check({name, " data"}, hs_data[idx], d);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] sum;
    logic [7:0]  gq[$];
    logic [7:0]  b;
    logic        bad;
    int          nbad, nw;
    logic [31:0] w;
    tbl[0] = '{seq: 32'h78563412, data: 32'h12345678};
    tbl[1] = '{seq: 32'hDEADBEEF, data: 32'hEFBEADDE};
    tbl[2] = '{seq: 32'h00FF0102, data: 32'h0201FF00};
    tbl[3] = '{seq: 32'h80000001, data: 32'h01000080};
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset wr_en", 32'(wr_en), 0);
    check("reset wr_addr", 32'(wr_addr), 0);
    check("reset wr_data", wr_data, 0);
    check("reset done", 32'(done), 0);
    check("reset frame_err", 32'(frame_err), 0);
    check("reset overrun", 32'(overrun), 0);
    check("reset checksum", checksum, 0);
    clear_mon();
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      send_seq(tbl[i].seq);
      wait_hs(i + 1, "table");
      check_write(i, "table", AW'(i), tbl[i].data);
      check("table done", 32'(done), 32'(i == 3));
      sum += tbl[i].data;
    end
    check("table wrapped addr", 32'(wr_addr), 0);
    check("table checksum", checksum, exp_ck(sum));
    send_seq(32'h55667788);
    tick(20);
    check("after done writes", 32'(hs_addr.size()), 4);
    check("after done wr_en", 32'(wr_en), 0);
    check("after done checksum", checksum, exp_ck(sum));
    do_reset();
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(20);
    check("glitch frame_err", 32'(fe_cnt), 0);
    check("glitch writes", 32'(hs_addr.size()), 0);
    send_seq(tbl[1].seq);
    wait_hs(1, "glitch");
    check_write(0, "glitch", 0, tbl[1].data);
    do_reset();
    send_byte(8'hAA, 1'b0);
    tick(5);
    check("bad stop frame_err", 32'(fe_cnt), 1);
    check("bad stop pulse width", 32'(fe_long), 0);
    check("bad stop writes", 32'(hs_addr.size()), 0);
    send_seq(tbl[2].seq);
    wait_hs(1, "bad stop");
    check_write(0, "bad stop", 0, tbl[2].data);
    do_reset();
    wr_ready = 1'b0;
    send_seq(tbl[0].seq);
    send_seq(tbl[1].seq);
    tick(5);
    check("overrun wr_en", 32'(wr_en), 1);
    check("overrun wr_addr", 32'(wr_addr), 0);
    check("overrun wr_data", wr_data, tbl[0].data);
    check("overrun flag", 32'(overrun), 1);
    wr_ready = 1'b1;
    wait_hs(1, "overrun");
    tick(30);
    check_write(0, "overrun", 0, tbl[0].data);
    check("overrun total writes", 32'(hs_addr.size()), 1);
    check("overrun next addr", 32'(wr_addr), 1);
    check("overrun wr_en low", 32'(wr_en), 0);
    send_byte(8'h11);
    send_byte(8'h22);
    rxd = 1'b0;
    tick(SW);
    b = 8'h33;
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      tick(SW);
    end
    rxd = b[3];
    tick(SW / 2);
    rst = 1'b1;
    tick(2);
    check("mid reset wr_en", 32'(wr_en), 0);
    check("mid reset wr_addr", 32'(wr_addr), 0);
    check("mid reset wr_data", wr_data, 0);
    check("mid reset overrun", 32'(overrun), 0);
    check("mid reset done", 32'(done), 0);
    check("mid reset checksum", checksum, 0);
    rst = 1'b0;
    rxd = 1'b1;
    clear_mon();
    tick(50);
    for (int i = 1; i <= 4; i++) send_seq({8'(i), 24'h0});
    wait_hs(4, "post reset");
    for (int i = 0; i < 4; i++) check_write(i, "post reset", AW'(i), 32'(i + 1));
    check("post reset checksum", checksum, exp_ck(32'h0000000A));
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rand_ready = 1'b1;
      gq.delete();
      nbad = 0;
      for (int i = 0; i < 22; i++) begin
        b = 8'($urandom_range(0, 255));
        bad = ($urandom_range(0, 5) == 0);
        send_byte(b, !bad);
        if (bad) nbad++;
        else gq.push_back(b);
      end
      nw = gq.size() / 4;
      if (nw > 4) nw = 4;
      wait_hs(nw, "random");
      tick(10);
      rand_ready = 1'b0;
      wr_ready = 1'b1;
      check("random total writes", 32'(hs_addr.size()), 32'(nw));
      sum = 0;
      for (int j = 0; j < nw; j++) begin
        w = gq[4*j] + (32'(gq[4*j+1]) << 8) + (32'(gq[4*j+2]) << 16) + (32'(gq[4*j+3]) << 24);
        check_write(j, "random", AW'(j), w);
        sum += w;
      end
      check("random done", 32'(done), 32'(nw == 4));
      check("random frame errors", 32'(fe_cnt), 32'(nbad));
      check("random checksum", checksum, exp_ck(sum));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
